mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TOTAL_BITS, default 16, operand/result width (two's complement, 1 sign bit).
REQ-002 Parameter FRACTION_BITS, default 12, fractional bits of operands and result.
REQ-003 Parameter NUM_REQ, default 4, number of requesters; ID width IDW = clog2(NUM_REQ), minimum 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a  input  NUM_REQ*TOTAL_BITS  multiplicands; requester i occupies slice [i*TOTAL_BITS +: TOTAL_BITS].
REQ-009 req_b  input  NUM_REQ*TOTAL_BITS  multipliers, same packing as req_a.
REQ-010 rsp_valid  output  1  result register holds a valid product.
REQ-011 rsp_ready  input  1  downstream accepts the result.
REQ-012 rsp_id  output  IDW  index of the requester that issued the product.
REQ-013 rsp_result  output  TOTAL_BITS  quantized product.
REQ-014 rsp_overflow  output  1  product magnitude exceeds the representable range.

Function
REQ-015 Transfer on a request port occurs when req_valid[i] && req_ready[i]; transfer on the response port occurs when rsp_valid && rsp_ready.
REQ-016 Two registered stages: S1 (operands + ID + valid), S2 (result + overflow + ID + valid = rsp_*).
REQ-017 S2 advances (loads from S1) when !rsp_valid || rsp_ready; S1 accepts a new request when S1 is empty or S1 advances in the same cycle.
REQ-018 req_ready[i] is high only for the arbitration winner, and only while S1 can accept; it depends combinationally on req_valid, never on rsp_ready of later cycles.
REQ-019 Arbitration: round-robin starting at pointer rr_ptr; winner = first i with req_valid[i] high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-020 On a transfer from winner w, rr_ptr <= (w+1) mod NUM_REQ; with no transfer, rr_ptr holds.
REQ-021 Latency: a request accepted in cycle n is presented on rsp_* in cycle n+2 with no backpressure; full throughput of one product per cycle.
REQ-022 Backpressure: while rsp_valid && !rsp_ready, rsp_* hold stable; S1 holds; req_ready is all-zero if S1 is also full.
REQ-023 Arithmetic: product magnitude = |a| * |b| over the TOTAL_BITS-1 magnitude bits; result = magnitude bits [TOTAL_BITS-2+FRACTION_BITS : FRACTION_BITS] (truncation), sign = sign(a) XOR sign(b), negative results returned in two's complement.
REQ-024 rsp_overflow = 1 when any magnitude-product bit in [2*TOTAL_BITS-2 : TOTAL_BITS-1+FRACTION_BITS] is set; rsp_result is still the truncated value (no saturation).
REQ-025 Responses leave in acceptance order; rsp_id equals the requester index latched in S1.
REQ-026 Requests with req_valid low never win; a requester may drop req_valid before being granted without any effect.

Reset
REQ-027 While rst is high at a clock edge: S1/S2 valid <= 0, rr_ptr <= 0, rsp_result <= 0, rsp_overflow <= 0, rsp_id <= 0.
REQ-028 req_ready is all-zero in any cycle where rst is high; in-flight products are discarded, never emitted.
REQ-029 First cycle after rst falls, requester 0 has highest priority.

Structure
REQ-030 Shared package holds Q-format constants (TOTAL_BITS=16, FRACTION_BITS=12) and the operand-slice helper width; NUM_REQ stays a local parameter.
REQ-031 The existing multiply unit is instantiated as the single combinational sub-module between S1 and S2; no other arithmetic is duplicated.

Verification
REQ-032 Single request: req0 a=0x1000, b=0x2000 accepted cycle n -> cycle n+2 rsp_result=0x2000, rsp_overflow=0, rsp_id=0.
REQ-033 Signed: req1 a=0xF000 (-1.0), b=0x2000 -> rsp_result=0xE000, rsp_overflow=0, rsp_id=1.
REQ-034 Overflow: a=0x4000, b=0x4000 -> rsp_overflow=1, rsp_result=0x0000.
REQ-035 Fairness: all four req_valid held high for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3, one response per cycle.
REQ-036 Backpressure: 3 back-to-back requests, rsp_ready low 4 cycles -> rsp_* stable, exactly 2 accepted until release, then all 3 responses in order with no loss or duplication.
REQ-037 Reset mid-flight: rst pulsed with S1 and S2 full -> rsp_valid=0 next cycle, no stale response emitted, next grant goes to requester 0.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg
//   Shared Q-format constants for the arbitrated fixed-point multiplier.
//   Q_TOTAL_BITS    : operand/result width (two's complement, one sign bit)
//   Q_FRACTION_BITS : fractional bits of operands and result
//   Q_MAG_BITS      : magnitude bits of a Q value (sign stripped)
//   Q_SLICE_W       : width of one requester's operand slice in the packed buses
package mult_arbiter_pkg;
  localparam int Q_TOTAL_BITS    = 16;
  localparam int Q_FRACTION_BITS = 12;
  localparam int Q_MAG_BITS      = Q_TOTAL_BITS - 1;
  localparam int Q_SLICE_W       = Q_TOTAL_BITS;
endpackage : mult_arbiter_pkg

// File: rtl/mult_arbiter_mul.sv
// mult_arbiter_mul
//   Combinational signed fixed-point multiply: sign-magnitude product,
//   truncated back to the operand Q format, with an overflow flag.
//   Ports:
//     i_a, i_b    : signed Q operands (TOTAL_BITS)
//     o_result    : truncated product, two's complement (TOTAL_BITS)
//     o_overflow  : product magnitude does not fit the result format
module mult_arbiter_mul
  import mult_arbiter_pkg::*;
#(
  parameter int TOTAL_BITS    = Q_TOTAL_BITS,
  parameter int FRACTION_BITS = Q_FRACTION_BITS
) (
  input  logic [TOTAL_BITS-1:0] i_a,
  input  logic [TOTAL_BITS-1:0] i_b,
  output logic [TOTAL_BITS-1:0] o_result,
  output logic                  o_overflow
);
  localparam int PW = 2 * TOTAL_BITS;

  logic [TOTAL_BITS-1:0] w_mag_a;
  logic [TOTAL_BITS-1:0] w_mag_b;
  logic [PW-1:0]         w_prod;
  logic [TOTAL_BITS-2:0] w_mag_res;
  logic                  w_neg;
  logic                  w_unused_low;

  // Magnitudes are kept TOTAL_BITS wide so the most negative operand
  // (e.g. 0x8000) yields its true magnitude instead of wrapping.
  assign w_mag_a = i_a[TOTAL_BITS-1] ? (~i_a + 1'b1) : i_a;
  assign w_mag_b = i_b[TOTAL_BITS-1] ? (~i_b + 1'b1) : i_b;
  assign w_prod  = PW'(w_mag_a) * PW'(w_mag_b);
  assign w_neg   = i_a[TOTAL_BITS-1] ^ i_b[TOTAL_BITS-1];

  assign w_mag_res = w_prod[TOTAL_BITS-2+FRACTION_BITS : FRACTION_BITS];

  // The top product bit can never be set (max magnitude product is
  // 2^(2*TOTAL_BITS-2)), so folding it into the overflow OR is harmless.
  assign o_overflow = |w_prod[PW-1 : TOTAL_BITS-1+FRACTION_BITS];
  assign o_result   = w_neg ? (~{1'b0, w_mag_res} + 1'b1) : {1'b0, w_mag_res};

  // Fraction bits below the result LSB are dropped by truncation.
  assign w_unused_low = ^w_prod[FRACTION_BITS-1:0];
endmodule : mult_arbiter_mul

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter in front of a two-stage pipelined fixed-point
//   multiplier. S1 holds the granted operands and requester ID; S2 holds the
//   product and is presented directly on the rsp_* port.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     req_valid/ready: per-requester handshake (NUM_REQ bits, one-hot ready)
//     req_a, req_b   : packed operands, requester i at [i*TOTAL_BITS +: TOTAL_BITS]
//     rsp_valid/ready: result handshake
//     rsp_id         : requester index of the presented product
//     rsp_result     : truncated signed product
//     rsp_overflow   : product magnitude exceeded the result range
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int TOTAL_BITS    = Q_TOTAL_BITS,
  parameter int FRACTION_BITS = Q_FRACTION_BITS,
  parameter int NUM_REQ       = 4,
  localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*TOTAL_BITS-1:0] req_a,
  input  logic [NUM_REQ*TOTAL_BITS-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [TOTAL_BITS-1:0]         rsp_result,
  output logic                          rsp_overflow
);
  logic [TOTAL_BITS-1:0] w_req_a [NUM_REQ];
  logic [TOTAL_BITS-1:0] w_req_b [NUM_REQ];

  logic                  r_s1_valid;
  logic [TOTAL_BITS-1:0] r_s1_a;
  logic [TOTAL_BITS-1:0] r_s1_b;
  logic [IDW-1:0]        r_s1_id;
  logic [IDW-1:0]        r_rr_ptr;

  logic                  w_s2_adv;
  logic                  w_s1_can_load;
  logic                  w_grant_found;
  logic [IDW-1:0]        w_grant_id;
  logic                  w_accept;
  logic [TOTAL_BITS-1:0] w_mul_result;
  logic                  w_mul_overflow;

  // (base + k) mod NUM_REQ without requiring NUM_REQ to be a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_req_a[gi]   = req_a[gi*TOTAL_BITS +: TOTAL_BITS];
      assign w_req_b[gi]   = req_b[gi*TOTAL_BITS +: TOTAL_BITS];
      assign req_ready[gi] = w_accept && (w_grant_id == IDW'(gi));
    end
  endgenerate

  assign w_s2_adv      = !rsp_valid || rsp_ready;
  // S1 drains into S2 whenever S2 advances, so it can refill in that cycle.
  assign w_s1_can_load = !r_s1_valid || w_s2_adv;
  assign w_accept      = w_grant_found && w_s1_can_load && !rst;

  // Round-robin search starting at r_rr_ptr; first valid requester wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_grant_found = 1'b1;
        w_grant_id    = wrap_add(r_rr_ptr, k);
      end
    end
  end

  mult_arbiter_mul #(
    .TOTAL_BITS    (TOTAL_BITS),
    .FRACTION_BITS (FRACTION_BITS)
  ) u_mul (
    .i_a        (r_s1_a),
    .i_b        (r_s1_b),
    .o_result   (w_mul_result),
    .o_overflow (w_mul_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_id      <= '0;
      r_rr_ptr     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          rsp_id       <= r_s1_id;
          rsp_result   <= w_mul_result;
          rsp_overflow <= w_mul_overflow;
        end
      end

      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_req_a[w_grant_id];
        r_s1_b     <= w_req_b[w_grant_id];
        r_s1_id    <= w_grant_id;
        r_rr_ptr   <= wrap_add(w_grant_id, 1);
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end
endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
//   Directed self-checking bench for mult_arbiter with hand-computed
//   expected values; one line per checked transaction.
module tb_mult_arbiter;
  localparam int TB = 16;
  localparam int NR = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*TB-1:0] req_a;
  logic [NR*TB-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [TB-1:0]   rsp_result;
  logic            rsp_overflow;

  int n_checks = 0;
  int n_errors = 0;

  mult_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [TB-1:0] a, input logic [TB-1:0] b);
    req_a[idx*TB +: TB] = a;
    req_b[idx*TB +: TB] = b;
  endtask

  // One isolated request with rsp_ready high: grant now, nothing at n+1,
  // product at n+2.
  task automatic single(input string tag, input int idx, input logic [TB-1:0] a,
                        input logic [TB-1:0] b, input logic [TB-1:0] er, input logic eo);
    set_op(idx, a, b);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'(1) << idx);
    tick();
    req_valid = '0;
    @(negedge clk);
    check({tag, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_result"}, 32'(rsp_result), 32'(er));
    check({tag, "_ovf"}, 32'(rsp_overflow), 32'(eo));
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    $display("txn %s: req%0d a=0x%04h b=0x%04h -> result=0x%04h ovf=%0d id=%0d",
             tag, idx, a, b, rsp_result, rsp_overflow, rsp_id);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset: outputs cleared, no grants even with every request raised.
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_ovf", 32'(rsp_overflow), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    $display("txn reset: ready=%b valid=%0d", req_ready, rsp_valid);
    tick();
    rst       = 1'b0;
    req_valid = '0;

    // Isolated products: basic, signed, overflow, neg*neg, truncation.
    single("one_x_two", 0, 16'h1000, 16'h2000, 16'h2000, 1'b0);
    single("neg_one_x_two", 1, 16'hF000, 16'h2000, 16'hE000, 1'b0);
    single("overflow", 2, 16'h4000, 16'h4000, 16'h0000, 1'b1);
    single("neg_x_neg", 3, 16'hE000, 16'hF800, 16'h1000, 1'b0);
    single("trunc_pos", 0, 16'h1800, 16'h0003, 16'h0004, 1'b0);
    single("trunc_neg", 1, 16'hE800, 16'h0003, 16'hFFFC, 1'b0);

    // Fairness from a fresh reset: all requesters held high for 8 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_op(i, 16'h1000, 16'((i + 1) << 12));
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) check($sformatf("fair_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        check($sformatf("fair_valid%0d", k), 32'(rsp_valid), 32'd1);
        check($sformatf("fair_id%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
        check($sformatf("fair_result%0d", k), 32'(rsp_result), 32'((((k - 2) % 4) + 1) << 12));
        $display("txn fair%0d: id=%0d result=0x%04h", k, rsp_id, rsp_result);
      end
      tick();
      if (k == 7) req_valid = '0;
    end
    @(negedge clk);
    check("fair_drain", 32'(rsp_valid), 32'd0);
    tick();

    // Backpressure: three back-to-back requests from requester 2.
    rsp_ready    = 1'b0;
    req_valid    = 4'b0100;
    set_op(2, 16'h1000, 16'h1000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 2 || c == 6) check($sformatf("bp_ready%0d", c), 32'(req_ready), 32'h4);
      else if (c < 6)      check($sformatf("bp_ready%0d", c), 32'(req_ready), 32'h0);
      if (c < 2 || c == 9) begin
        check($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd0);
      end else begin
        check($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'd1);
        check($sformatf("bp_id%0d", c), 32'(rsp_id), 32'd2);
        check($sformatf("bp_result%0d", c), 32'(rsp_result),
              (c <= 6) ? 32'h1000 : ((c == 7) ? 32'h2000 : 32'h3000));
        $display("txn bp%0d: ready=%0d id=%0d result=0x%04h", c, rsp_ready, rsp_id, rsp_result);
      end
      tick();
      if (c == 0) set_op(2, 16'h2000, 16'h1000);
      if (c == 1) set_op(2, 16'h3000, 16'h1000);
      if (c == 5) rsp_ready = 1'b1;
      if (c == 6) req_valid = '0;
    end

    // Reset with both stages full: nothing stale may come out afterwards.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_op(3, 16'h1000, 16'h5000);
    @(negedge clk);
    check("mr_ready0", 32'(req_ready), 32'h8);
    tick();
    @(negedge clk);
    check("mr_ready1", 32'(req_ready), 32'h8);
    tick();
    @(negedge clk);
    check("mr_full_valid", 32'(rsp_valid), 32'd1);
    check("mr_full_ready", 32'(req_ready), 32'h0);
    tick();
    rst       = 1'b1;
    req_valid = '1;
    @(negedge clk);
    check("mr_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    set_op(0, 16'h1000, 16'h3000);
    @(negedge clk);
    check("mr_post_valid", 32'(rsp_valid), 32'd0);
    check("mr_post_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mr_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mr_rsp_id", 32'(rsp_id), 32'd0);
    check("mr_rsp_result", 32'(rsp_result), 32'h3000);
    $display("txn midreset: id=%0d result=0x%04h", rsp_id, rsp_result);
    tick();
    @(negedge clk);
    check("mr_drain", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule : tb_mult_arbiter
